// File: rtl/i2c_req_arbiter.sv
// Round-robin share of one I2C_Controller between two 24-bit write requesters; decisions only on ctrl-clock ticks, requesters hold VALID until DONE.
// Define I2C_ARB_RETRY_EN to bound NACK retries at MAX_RETRY and report ERR; otherwise a NACKed write retries forever.
module i2c_req_arbiter #(
   parameter int CLK_DIV   = 270,
   parameter int MAX_RETRY = 3
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iREQ0_VALID,
   input  logic [23:0] iREQ0_DATA,
   output logic        oREQ0_DONE,
   output logic        oREQ0_ERR,
   input  logic        iREQ1_VALID,
   input  logic [23:0] iREQ1_DATA,
   output logic        oREQ1_DONE,
   output logic        oREQ1_ERR,
   output logic        oI2C_CTRL_CLK,
   output logic [23:0] oI2C_DATA,
   output logic        oI2C_GO,
   input  logic        iI2C_END,
   input  logic        iI2C_ACK,
   output logic        oBUSY
);
   localparam int DivW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} stateT;

   stateT            state, stateNxt;
   logic [DivW-1:0]  divCnt;
   logic             divWrap, tick;
   logic             grant, grantNxt;
   logic             rrPtr, rrNxt;
   logic             nackSeen, nackNxt;
   logic [23:0]      dataNxt;
   logic             goNxt, doneNxt, errNxt;

`ifdef I2C_ARB_RETRY_EN
   localparam int RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RetryW-1:0] retryCnt, retryNxt;
   logic              giveUp, giveUpNxt;
`else
   logic unusedRetryCfg;
   assign unusedRetryCfg = (MAX_RETRY > 0);
   assign oREQ0_ERR = 1'b0;
   assign oREQ1_ERR = 1'b0;
`endif

   // tick marks the iCLK cycle in which the controller clock rises
   assign divWrap = (divCnt == DivW'(CLK_DIV));
   assign tick    = divWrap && !oI2C_CTRL_CLK;
   assign oBUSY   = (state != IDLE);

   always_comb begin
      stateNxt = state;
      grantNxt = grant;
      rrNxt    = rrPtr;
      nackNxt  = nackSeen;
      dataNxt  = oI2C_DATA;
      goNxt    = oI2C_GO;
      doneNxt  = 1'b0;
      errNxt   = 1'b0;
`ifdef I2C_ARB_RETRY_EN
      retryNxt  = retryCnt;
      giveUpNxt = giveUp;
`endif
      if (tick) begin
         case (state)
            IDLE: begin
               if (iREQ0_VALID || iREQ1_VALID) begin
                  grantNxt = (iREQ0_VALID && iREQ1_VALID) ? rrPtr : iREQ1_VALID;
                  dataNxt  = grantNxt ? iREQ1_DATA : iREQ0_DATA;
                  goNxt    = 1'b1;
                  stateNxt = BUSY;
`ifdef I2C_ARB_RETRY_EN
                  retryNxt = '0;
`endif
               end
            end
            BUSY: begin
               if (iI2C_END) begin
                  goNxt    = 1'b0;
                  nackNxt  = iI2C_ACK;
                  stateNxt = RELEASE;
`ifdef I2C_ARB_RETRY_EN
                  giveUpNxt = 1'b0;
                  if (iI2C_ACK) begin
                     if (retryCnt < RetryW'(MAX_RETRY)) retryNxt = retryCnt + 1'b1;
                     else giveUpNxt = 1'b1;
                  end
`endif
               end
            end
            RELEASE: begin
               // wait for the controller to drop END before finishing or re-issuing
               if (!iI2C_END) begin
                  if (!nackSeen) begin
                     doneNxt  = 1'b1;
                     rrNxt    = ~grant;
                     stateNxt = IDLE;
                  end
`ifdef I2C_ARB_RETRY_EN
                  else if (giveUp) begin
                     doneNxt  = 1'b1;
                     errNxt   = 1'b1;
                     stateNxt = IDLE;
                  end
`endif
                  else begin
                     goNxt    = 1'b1;
                     stateNxt = BUSY;
                  end
               end
            end
            default: stateNxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         divCnt        <= '0;
         oI2C_CTRL_CLK <= 1'b0;
         state         <= IDLE;
         grant         <= 1'b0;
         rrPtr         <= 1'b0;
         nackSeen      <= 1'b0;
         oI2C_DATA     <= '0;
         oI2C_GO       <= 1'b0;
         oREQ0_DONE    <= 1'b0;
         oREQ1_DONE    <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
         retryCnt      <= '0;
         giveUp        <= 1'b0;
         oREQ0_ERR     <= 1'b0;
         oREQ1_ERR     <= 1'b0;
`endif
      end else begin
         divCnt <= divWrap ? '0 : divCnt + 1'b1;
         if (divWrap) oI2C_CTRL_CLK <= ~oI2C_CTRL_CLK;
         state      <= stateNxt;
         grant      <= grantNxt;
         rrPtr      <= rrNxt;
         nackSeen   <= nackNxt;
         oI2C_DATA  <= dataNxt;
         oI2C_GO    <= goNxt;
         oREQ0_DONE <= doneNxt && !grant;
         oREQ1_DONE <= doneNxt && grant;
`ifdef I2C_ARB_RETRY_EN
         retryCnt   <= retryNxt;
         giveUp     <= giveUpNxt;
         oREQ0_ERR  <= errNxt && !grant;
         oREQ1_ERR  <= errNxt && grant;
`endif
      end
   end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: controller model answers END two ctrl-clock periods after GO, with scripted NACKs.
module tb_i2c_req_arbiter;
   localparam int CLK_DIV   = 1;
   localparam int MAX_RETRY = 3;
   localparam int CTRL_LAT  = 2;

   logic        clk = 1'b0, rst = 1'b1;
   logic        valid0 = 1'b0, valid1 = 1'b0;
   logic [23:0] data0 = '0, data1 = '0;
   logic        done0, err0, done1, err1, ctrlClk, go, busy;
   logic [23:0] i2cData;
   logic        ctrlEnd = 1'b0, ctrlAck = 1'b0;

   i2c_req_arbiter #(.CLK_DIV(CLK_DIV), .MAX_RETRY(MAX_RETRY)) dut (
      .iCLK(clk), .iRST(rst),
      .iREQ0_VALID(valid0), .iREQ0_DATA(data0), .oREQ0_DONE(done0), .oREQ0_ERR(err0),
      .iREQ1_VALID(valid1), .iREQ1_DATA(data1), .oREQ1_DONE(done1), .oREQ1_ERR(err1),
      .oI2C_CTRL_CLK(ctrlClk), .oI2C_DATA(i2cData), .oI2C_GO(go),
      .iI2C_END(ctrlEnd), .iI2C_ACK(ctrlAck), .oBUSY(busy)
   );

   always #5 clk = ~clk;

   int nChecks = 0, nPass = 0;

   // controller model: END after CTRL_LAT ctrl periods of GO, cleared once GO drops
   int ctrlCnt = 0, endCount = 0, nackUpTo = 0;
   bit nackForever = 1'b0;
   always @(negedge ctrlClk or posedge rst) begin
      if (rst) begin
         ctrlEnd <= 1'b0; ctrlAck <= 1'b0; ctrlCnt <= 0;
      end else if (!go) begin
         ctrlEnd <= 1'b0; ctrlCnt <= 0;
      end else if (!ctrlEnd) begin
         if (ctrlCnt == CTRL_LAT - 1) begin
            ctrlEnd  <= 1'b1;
            ctrlAck  <= nackForever || (endCount < nackUpTo);
            endCount <= endCount + 1;
            ctrlCnt  <= 0;
         end else begin
            ctrlCnt <= ctrlCnt + 1;
         end
      end
   end

   logic [23:0] goLog[$];
   int          doneLog[$];
   int          done0Cnt = 0, done1Cnt = 0, err0Cnt = 0, err1Cnt = 0, doneWide = 0, errAlone = 0;
   logic        goPrev = 1'b0, d0Prev = 1'b0, d1Prev = 1'b0;
   always @(negedge clk) begin
      if (go && !goPrev) goLog.push_back(i2cData);
      if (done0) begin done0Cnt++; doneLog.push_back(0); end
      if (done1) begin done1Cnt++; doneLog.push_back(1); end
      if (err0) err0Cnt++;
      if (err1) err1Cnt++;
      if ((done0 && d0Prev) || (done1 && d1Prev)) doneWide++;
      if ((err0 && !done0) || (err1 && !done1)) errAlone++;
      goPrev = go; d0Prev = done0; d1Prev = done1;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int base;
      base = done0Cnt + done1Cnt;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         if (done0Cnt + done1Cnt != base) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      valid0 = 1'b0; valid1 = 1'b0; rst = 1'b1;
      repeat (5) step();
      nChecks++; if (go !== 1'b0) $display("FAIL reset_go: got %b want 0", go); else nPass++;
      nChecks++; if (ctrlClk !== 1'b0) $display("FAIL reset_ctrlclk: got %b want 0", ctrlClk); else nPass++;
      nChecks++; if (i2cData !== 24'h0) $display("FAIL reset_data: got %h want 000000", i2cData); else nPass++;
      nChecks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else nPass++;
      nChecks++;
      if ({done0, err0, done1, err1} !== 4'b0) $display("FAIL reset_done_err: got %b want 0000", {done0, err0, done1, err1});
      else nPass++;
      rst = 1'b0;
   endtask

   task automatic test_divider();
      int t0 = -1, t1 = -1, cyc = 0;
      logic prev;
      prev = ctrlClk;
      for (int i = 0; i < 40 && t1 < 0; i++) begin
         step(); cyc++;
         if (ctrlClk && !prev) begin
            if (t0 < 0) t0 = cyc; else t1 = cyc;
         end
         prev = ctrlClk;
      end
      nChecks++;
      if (t1 - t0 != 2 * (CLK_DIV + 1)) $display("FAIL divider_period: got %0d want %0d", t1 - t0, 2 * (CLK_DIV + 1));
      else nPass++;
   endtask

   task automatic test_single();
      int g, d0, e0, lat = -1;
      bit ok;
      logic [23:0] got;
      g = goLog.size(); d0 = done0Cnt; e0 = err0Cnt;
      nackForever = 1'b0; nackUpTo = endCount;
      data0 = 24'h200227; valid0 = 1'b1;
      for (int i = 1; i <= 2 * (CLK_DIV + 1) && lat < 0; i++) begin
         step();
         if (go) lat = i;
      end
      nChecks++; if (lat < 0) $display("FAIL single_first_tick: GO not seen within one ctrl period"); else nPass++;
      wait_done(300, ok);
      valid0 = 1'b0;
      nChecks++; if (ok !== 1'b1) $display("FAIL single_timeout: done seen %b want 1", ok); else nPass++;
      nChecks++; if (goLog.size() - g != 1) $display("FAIL single_go_count: got %0d want 1", goLog.size() - g); else nPass++;
      got = (goLog.size() > g) ? goLog[g] : 24'hxxxxxx;
      nChecks++; if (got !== 24'h200227) $display("FAIL single_data: got %h want 200227", got); else nPass++;
      nChecks++; if (done0Cnt - d0 != 1) $display("FAIL single_done: got %0d want 1", done0Cnt - d0); else nPass++;
      nChecks++; if (err0Cnt - e0 != 0) $display("FAIL single_err: got %0d want 0", err0Cnt - e0); else nPass++;
      step();
      nChecks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else nPass++;
   endtask

   task automatic test_both();
      int g, n, gotIdx;
      bit ok;
      logic [23:0] got, expData;
      do_reset();
      g = goLog.size(); n = doneLog.size();
      nackUpTo = endCount;
      data0 = 24'hc00253; data1 = 24'h2005fd; valid0 = 1'b1; valid1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_done(300, ok);
         nChecks++; if (ok !== 1'b1) $display("FAIL both_timeout_%0d: done seen %b want 1", k, ok); else nPass++;
      end
      valid0 = 1'b0; valid1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         gotIdx  = (doneLog.size() > n + k) ? doneLog[n + k] : -1;
         got     = (goLog.size() > g + k) ? goLog[g + k] : 24'hxxxxxx;
         expData = (k % 2 == 1) ? data1 : data0;
         nChecks++; if (gotIdx != k % 2) $display("FAIL both_grant_%0d: got req%0d want req%0d", k, gotIdx, k % 2); else nPass++;
         nChecks++; if (got !== expData) $display("FAIL both_data_%0d: got %h want %h", k, got, expData); else nPass++;
      end
      nChecks++; if (doneWide != 0) $display("FAIL done_pulse_width: got %0d wide pulses want 0", doneWide); else nPass++;
   endtask

   task automatic test_retry();
      int g, d0, d1, e1, bad = 0;
      bit ok;
      g = goLog.size(); d0 = done0Cnt; d1 = done1Cnt; e1 = err1Cnt;
      nackUpTo = endCount + 2;
      data1 = 24'h20a5c3; valid1 = 1'b1;
      wait_done(400, ok);
      valid1 = 1'b0;
      nChecks++; if (ok !== 1'b1) $display("FAIL retry_timeout: done seen %b want 1", ok); else nPass++;
      nChecks++; if (goLog.size() - g != 3) $display("FAIL retry_go_count: got %0d want 3", goLog.size() - g); else nPass++;
      for (int i = g; i < goLog.size(); i++) if (goLog[i] !== 24'h20a5c3) bad++;
      nChecks++; if (bad != 0) $display("FAIL retry_data: %0d GO pulses carried data other than 20a5c3", bad); else nPass++;
      nChecks++;
      if (done1Cnt - d1 != 1 || done0Cnt != d0) $display("FAIL retry_done: got req1 %0d req0 %0d want 1 0", done1Cnt - d1, done0Cnt - d0);
      else nPass++;
      nChecks++; if (err1Cnt - e1 != 0) $display("FAIL retry_err: got %0d want 0", err1Cnt - e1); else nPass++;
   endtask

   task automatic test_nack_always();
      int g, d0, e0, bad = 0;
      bit ok;
      g = goLog.size(); d0 = done0Cnt; e0 = err0Cnt;
      nackForever = 1'b1;
      data0 = 24'h20aa55; valid0 = 1'b1;
`ifdef I2C_ARB_RETRY_EN
      wait_done(800, ok);
      valid0 = 1'b0; nackForever = 1'b0;
      nChecks++; if (ok !== 1'b1) $display("FAIL nack_timeout: done seen %b want 1", ok); else nPass++;
      nChecks++;
      if (goLog.size() - g != MAX_RETRY + 1) $display("FAIL nack_go_count: got %0d want %0d", goLog.size() - g, MAX_RETRY + 1);
      else nPass++;
      nChecks++; if (err0Cnt - e0 != 1) $display("FAIL nack_err: got %0d want 1", err0Cnt - e0); else nPass++;
      nChecks++; if (errAlone != 0) $display("FAIL nack_err_with_done: got %0d lone ERR pulses want 0", errAlone); else nPass++;
      nChecks++; if (done0Cnt - d0 != 1) $display("FAIL nack_done: got %0d want 1", done0Cnt - d0); else nPass++;
`else
      ok = 1'b1;
      repeat (300) step();
      nChecks++; if (done0Cnt - d0 != 0) $display("FAIL nack_done: got %0d want 0", done0Cnt - d0); else nPass++;
      nChecks++; if (goLog.size() - g < 10) $display("FAIL nack_go_count: got %0d want at least 10", goLog.size() - g); else nPass++;
      nChecks++; if (err0Cnt - e0 != 0) $display("FAIL nack_err: got %0d want 0", err0Cnt - e0); else nPass++;
      valid0 = 1'b0; nackForever = 1'b0;
      do_reset();
`endif
      for (int i = g; i < goLog.size(); i++) if (goLog[i] !== 24'h20aa55) bad++;
      nChecks++; if (bad != 0 || !ok) $display("FAIL nack_data: %0d GO pulses carried other data, done seen %b", bad, ok); else nPass++;
   endtask

   task automatic test_reset_mid();
      int g, d1, w = 0;
      bit ok;
      logic [23:0] got;
      d1 = done1Cnt;
      nackUpTo = endCount;
      data1 = 24'h20c0de; valid1 = 1'b1;
      while (!go && w < 20) begin step(); w++; end
      step(); step();
      rst = 1'b1;
      #1;
      nChecks++; if (go !== 1'b0) $display("FAIL rstmid_go: got %b want 0", go); else nPass++;
      nChecks++; if (ctrlClk !== 1'b0) $display("FAIL rstmid_ctrlclk: got %b want 0", ctrlClk); else nPass++;
      nChecks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else nPass++;
      repeat (3) step();
      rst = 1'b0;
      g = goLog.size();
      wait_done(300, ok);
      valid1 = 1'b0;
      nChecks++; if (ok !== 1'b1) $display("FAIL rstmid_timeout: done seen %b want 1", ok); else nPass++;
      nChecks++; if (done1Cnt - d1 != 1) $display("FAIL rstmid_done: got %0d want 1", done1Cnt - d1); else nPass++;
      got = (goLog.size() > g) ? goLog[g] : 24'hxxxxxx;
      nChecks++; if (got !== 24'h20c0de) $display("FAIL rstmid_data: got %h want 20c0de", got); else nPass++;
   endtask

   task automatic test_random();
      int pat, k, g, n, expGrant, gotIdx, bad, ptr;
      bit ok;
      logic [23:0] r0, r1, expData;
      do_reset();
      ptr = 0;
      for (int it = 0; it < 12; it++) begin
         pat = $urandom_range(1, 3);
         k   = $urandom_range(0, 2);
         r0  = 24'($urandom);
         r1  = 24'($urandom);
         expGrant = (pat == 3) ? ptr : ((pat == 2) ? 1 : 0);
         expData  = (expGrant == 1) ? r1 : r0;
         g = goLog.size(); n = doneLog.size();
         nackUpTo = endCount + k;
         data0 = r0; data1 = r1; valid0 = pat[0]; valid1 = pat[1];
         wait_done(400, ok);
         valid0 = 1'b0; valid1 = 1'b0;
         gotIdx = (ok && doneLog.size() > n) ? doneLog[n] : -1;
         nChecks++; if (gotIdx != expGrant) $display("FAIL rand_grant_%0d: got req%0d want req%0d", it, gotIdx, expGrant); else nPass++;
         nChecks++; if (goLog.size() - g != k + 1) $display("FAIL rand_go_count_%0d: got %0d want %0d", it, goLog.size() - g, k + 1); else nPass++;
         bad = 0;
         for (int i = g; i < goLog.size(); i++) if (goLog[i] !== expData) bad++;
         nChecks++; if (bad != 0) $display("FAIL rand_data_%0d: %0d GO pulses differ from %h", it, bad, expData); else nPass++;
         ptr = 1 - expGrant;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_divider();
      test_single();
      test_both();
      test_retry();
      test_nack_always();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
